// File: rtl/updown_sweep_pkg.sv
// updown_sweep_pkg: shared state encoding and default widths for the
// up/down sweep controller and its step counter.
package updown_sweep_pkg;

  // Controller states: idle, climbing toward HI, descending toward LO.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UP_RUN   = 2'd1,
    DOWN_RUN = 2'd2
  } sweep_state_t;

  localparam int DEFAULT_W     = 4;
  localparam int DEFAULT_REP_W = 4;

endpackage

// File: rtl/updown_sweep_ctrl_counter.sv
// sweep_step_counter: W-bit loadable up/down register. Load has priority
// over stepping; reset is synchronous and active-high.
module sweep_step_counter
  import updown_sweep_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_en,
  input  logic         i_up,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Counter register: reset, else load, else one step in the chosen direction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_value;
    end else if (i_en) begin
      r_q <= i_up ? (r_q + W'(1)) : (r_q - W'(1));
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: accepts a (LO, HI, REPS) sweep command and drives the
// step counter through REPS+1 triangle sweeps LO->HI->LO.
// Optional feature: define UPDOWN_SWEEP_PAUSE_EN to add the PAUSE port,
// which freezes an active sweep while high.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int REP_W = DEFAULT_REP_W
) (
  input  logic             CK,
  input  logic             RES,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [W-1:0]     CMD_LO,
  input  logic [W-1:0]     CMD_HI,
  input  logic [REP_W-1:0] CMD_REPS,
  input  logic             ABORT,
`ifdef UPDOWN_SWEEP_PAUSE_EN
  input  logic             PAUSE,
`endif
  output logic             UP,
  output logic [W-1:0]     Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  sweep_state_t     r_state;
  logic             r_up;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [REP_W-1:0] r_rep;
  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_hi;

  logic             w_accept;
  logic             w_pause;
  logic             w_load;
  logic [W-1:0]     w_load_value;
  logic             w_en;
  logic             w_dir_up;
  logic [W-1:0]     w_q;
  logic [W-1:0]     w_q_inc;
  logic [W-1:0]     w_q_dec;

`ifdef UPDOWN_SWEEP_PAUSE_EN
  assign w_pause = PAUSE;
`else
  assign w_pause = 1'b0;
`endif

  assign CMD_READY = (r_state == IDLE) && !RES;
  assign w_accept  = CMD_VALID && CMD_READY;
  assign w_q_inc   = w_q + W'(1);
  assign w_q_dec   = w_q - W'(1);

  // Counter control: load LO on a good command, step while a sweep runs unfrozen.
  always_comb begin
    w_load       = 1'b0;
    w_load_value = CMD_LO;
    w_en         = 1'b0;
    w_dir_up     = 1'b0;
    case (r_state)
      IDLE: begin
        w_load = w_accept && (CMD_LO <= CMD_HI);
      end
      UP_RUN: begin
        w_en     = !ABORT && !w_pause;
        w_dir_up = 1'b1;
      end
      DOWN_RUN: begin
        w_en     = !ABORT && !w_pause;
        w_dir_up = 1'b0;
      end
      default: begin
        w_en = 1'b0;
      end
    endcase
  end

  sweep_step_counter #(
    .W(W)
  ) u_counter (
    .i_clk       (CK),
    .i_rst       (RES),
    .i_load      (w_load),
    .i_load_value(w_load_value),
    .i_en        (w_en),
    .i_up        (w_dir_up),
    .o_q         (w_q)
  );

  // Sweep FSM with registered UP/BUSY/DONE/ERR; turns at HI, then at LO either repeats or finishes.
  always_ff @(posedge CK) begin
    if (RES) begin
      r_state <= IDLE;
      r_up    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rep   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (CMD_LO > CMD_HI) begin
              r_err <= 1'b1;
            end else if (CMD_LO == CMD_HI) begin
              r_done <= 1'b1;
            end else begin
              r_state <= UP_RUN;
              r_up    <= 1'b1;
              r_busy  <= 1'b1;
              r_lo    <= CMD_LO;
              r_hi    <= CMD_HI;
              r_rep   <= CMD_REPS;
            end
          end
        end
        UP_RUN: begin
          if (ABORT) begin
            r_state <= IDLE;
            r_up    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!w_pause && (w_q_inc == r_hi)) begin
            r_state <= DOWN_RUN;
            r_up    <= 1'b0;
          end
        end
        DOWN_RUN: begin
          if (ABORT) begin
            r_state <= IDLE;
            r_up    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!w_pause && (w_q_dec == r_lo)) begin
            if (r_rep == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_rep   <= r_rep - REP_W'(1);
              r_state <= UP_RUN;
              r_up    <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_up    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign UP   = r_up;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;
  assign Q    = w_q;

endmodule
